// File: rtl/schmidl_cox_sync_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// schmidl_cox_pkg
// Shared definitions for the Schmidl-Cox frame synchronisation controller:
// FSM state encoding, default peak-search window length, stream data width
// and a width helper for counters sized from a count.
// ---------------------------------------------------------------------------
package schmidl_cox_pkg;

   localparam int PEAK_WIN_DEFAULT = 512;
   localparam int DATA_W           = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_TRACK  = 2'd2,
      ST_FRAME  = 2'd3
   } sc_state_e;

   // Bits needed to index 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/schmidl_cox_sync_ctrl_if.sv
// ---------------------------------------------------------------------------
// schmidl_cox_sync_ctrl_if
// Stream bundle of the sync controller.
//   m_tdata/m_tvalid/m_tready : metric stream M(d) into the controller
//   i_tdata/i_tvalid/i_tready : [I,Q] sample stream, 1:1 with the metric
//   o_tdata/o_tlast/o_tvalid/o_tready : framed sample output
// Modports: slave = controller side, master = source/sink side.
// ---------------------------------------------------------------------------
interface schmidl_cox_sync_ctrl_if;
   import schmidl_cox_pkg::*;

   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic [DATA_W-1:0] i_tdata;
   logic              i_tvalid;
   logic              i_tready;
   logic [DATA_W-1:0] o_tdata;
   logic              o_tlast;
   logic              o_tvalid;
   logic              o_tready;

   modport slave (
      input  m_tdata, m_tvalid,
      output m_tready,
      input  i_tdata, i_tvalid,
      output i_tready,
      output o_tdata, o_tlast, o_tvalid,
      input  o_tready
   );

   modport master (
      output m_tdata, m_tvalid,
      input  m_tready,
      output i_tdata, i_tvalid,
      input  i_tready,
      input  o_tdata, o_tlast, o_tvalid,
      output o_tready
   );

endinterface

// File: rtl/schmidl_cox_sync_ctrl_peak_tracker.sv
// ---------------------------------------------------------------------------
// sc_peak_tracker
// Running maximum of the metric inside the peak-search window, plus the
// number of pairs seen since that maximum.
//   clk    : clock
//   reset  : synchronous clear of peak and offset
//   load   : first pair of a window; peak <= din, offset <= 0
//   update : further window pair; strictly larger din replaces the peak and
//            zeroes the offset, otherwise the offset advances
//   din    : metric of the pair presented this cycle
//   value  : peak including the pair presented this cycle
//   offset : pairs since peak including the pair presented this cycle
// value/offset are look-ahead so the controller can capture the final
// result on the same edge that consumes the last window pair.
// ---------------------------------------------------------------------------
module sc_peak_tracker
   import schmidl_cox_pkg::*;
#(
   parameter int PEAK_WIN = PEAK_WIN_DEFAULT,
   parameter int OFF_W    = cnt_w(PEAK_WIN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              update,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] value,
   output logic [OFF_W-1:0]  offset
);

   localparam logic [OFF_W-1:0] OFF_ONE = 1;

   logic [DATA_W-1:0] peak_q;
   logic [OFF_W-1:0]  off_q;

   always_comb begin
      value  = peak_q;
      offset = off_q;
      if (load) begin
         value  = din;
         offset = '0;
      end else if (update) begin
         // Ties keep the earlier peak, so only a strictly larger metric wins.
         if (din > peak_q) begin
            value  = din;
            offset = '0;
         end else begin
            offset = off_q + OFF_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_q <= '0;
         off_q  <= '0;
      end else begin
         peak_q <= value;
         off_q  <= offset;
      end
   end

endmodule

// File: rtl/schmidl_cox_sync_ctrl.sv
// ---------------------------------------------------------------------------
// schmidl_cox_sync_ctrl
// Frame synchroniser driven by a Schmidl-Cox timing metric. It discards
// metric/sample pairs until the metric strictly exceeds the threshold, then
// tracks the peak over a window of PEAK_WIN pairs, reports the peak, and
// forwards the following frame_len samples as one framed output burst.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : synchronous soft clear, same effect as reset
//   enable       : 1 = search for frames, 0 = discard input
//   threshold    : unsigned metric threshold, compared live
//   frame_len    : samples per frame, sampled when a frame starts (0 -> 1)
//   strm         : metric / sample / framed-output streams (slave modport)
//   detect       : one-cycle pulse when a frame starts
//   peak_value   : peak metric of the last detection
//   peak_offset  : pairs from the peak to the window end
//   state        : current FSM state
// ---------------------------------------------------------------------------
module schmidl_cox_sync_ctrl
   import schmidl_cox_pkg::*;
#(
   parameter int PEAK_WIN    = PEAK_WIN_DEFAULT,
   parameter int FRAME_LEN_W = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          enable,
   input  logic [DATA_W-1:0]             threshold,
   input  logic [FRAME_LEN_W-1:0]        frame_len,
   schmidl_cox_sync_ctrl_if.slave        strm,
   output logic                          detect,
   output logic [DATA_W-1:0]             peak_value,
   output logic [cnt_w(PEAK_WIN)-1:0]    peak_offset,
   output logic [1:0]                    state
);

   localparam int OFF_W = cnt_w(PEAK_WIN);
   localparam int WIN_W = $clog2(PEAK_WIN + 1);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] SEARCH = ST_SEARCH;
   localparam logic [1:0] TRACK  = ST_TRACK;
   localparam logic [1:0] FRAME  = ST_FRAME;

   localparam logic [WIN_W-1:0]       WIN_ONE  = 1;
   localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(PEAK_WIN);
   localparam logic [FRAME_LEN_W-1:0] LEN_ONE  = 1;
   // A one-pair window completes on the threshold crossing itself.
   localparam bit                     WIN_SINGLE = (PEAK_WIN == 1);

   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [WIN_W-1:0]       win_cnt;
   logic [FRAME_LEN_W-1:0] beat_cnt;
   logic [FRAME_LEN_W-1:0] len_q;

   logic                   in_frame;
   logic                   ready;
   logic                   pair_vld;
   logic                   pair_fire;
   logic                   crossing;
   logic                   track_load;
   logic                   track_upd;
   logic                   win_done;
   logic                   beat_fire;
   logic                   last_beat;
   logic                   enter_frame;
   logic                   sclr;
   logic [DATA_W-1:0]      trk_value;
   logic [OFF_W-1:0]       trk_offset;

   assign sclr      = reset | clear;
   assign in_frame  = (state_q == FRAME);
   assign pair_vld  = strm.m_tvalid & strm.i_tvalid;

   // Outside FRAME every pair is swallowed; inside FRAME the output sink
   // paces both input streams with no buffering in between.
   assign ready     = in_frame ? strm.o_tready : 1'b1;
   assign pair_fire = pair_vld & ready;
   assign crossing  = (strm.m_tdata > threshold);

   assign track_load = (state_q == SEARCH) & enable & pair_fire & crossing;
   assign track_upd  = (state_q == TRACK)  & enable & pair_fire;
   assign win_done   = (track_load & WIN_SINGLE) |
                       (track_upd & ((win_cnt + WIN_ONE) == WIN_LAST));

   assign beat_fire  = in_frame & pair_vld & strm.o_tready;
   assign last_beat  = (beat_cnt == (len_q - LEN_ONE));

   assign strm.m_tready = ready;
   assign strm.i_tready = ready;
   assign strm.o_tdata  = strm.i_tdata;
   assign strm.o_tvalid = in_frame & pair_vld;
   assign strm.o_tlast  = in_frame & pair_vld & last_beat;

   assign state = state_q;

   sc_peak_tracker #(
      .PEAK_WIN (PEAK_WIN),
      .OFF_W    (OFF_W)
   ) u_peak (
      .clk    (clk),
      .reset  (sclr),
      .load   (track_load),
      .update (track_upd),
      .din    (strm.m_tdata),
      .value  (trk_value),
      .offset (trk_offset)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = SEARCH;
         end
         SEARCH: begin
            if (!enable)        state_d = IDLE;
            else if (win_done)  state_d = FRAME;
            else if (track_load) state_d = TRACK;
         end
         TRACK: begin
            if (!enable)       state_d = IDLE;
            else if (win_done) state_d = FRAME;
         end
         FRAME: begin
            // A started frame always completes; enable only picks the exit.
            if (beat_fire && last_beat) state_d = enable ? SEARCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_frame = (state_d == FRAME) & ~in_frame;

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q     <= IDLE;
         win_cnt     <= '0;
         beat_cnt    <= '0;
         len_q       <= '0;
         detect      <= 1'b0;
         peak_value  <= '0;
         peak_offset <= '0;
      end else begin
         state_q <= state_d;
         detect  <= enter_frame;

         if (track_load)     win_cnt <= WIN_ONE;
         else if (track_upd) win_cnt <= win_cnt + WIN_ONE;

         if (enter_frame) begin
            len_q       <= (frame_len == '0) ? LEN_ONE : frame_len;
            beat_cnt    <= '0;
            peak_value  <= trk_value;
            peak_offset <= trk_offset;
         end else if (beat_fire) begin
            beat_cnt <= last_beat ? '0 : (beat_cnt + LEN_ONE);
         end
      end
   end

endmodule

// File: tb/tb_schmidl_cox_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_schmidl_cox_sync_ctrl
// Bench for schmidl_cox_sync_ctrl with PEAK_WIN = 8: a per-cycle vector
// table for the basic detect-and-frame sequence, hand-written sequences for
// ties, back-pressure, enable drop, reset/clear mid-frame and frame_len = 0,
// and random streams checked against a pair-sequence reference model.
// ---------------------------------------------------------------------------
module tb_schmidl_cox_sync_ctrl;

   localparam int PW   = 8;
   localparam int FLW  = 16;
   localparam int NRND = 240;

   logic            clk = 1'b0;
   logic            reset;
   logic            clear;
   logic            enable;
   logic [31:0]     threshold;
   logic [FLW-1:0]  frame_len;
   logic            detect;
   logic [31:0]     peak_value;
   logic [2:0]      peak_offset;
   logic [1:0]      state;

   always #5 clk = ~clk;

   schmidl_cox_sync_ctrl_if bus();

   schmidl_cox_sync_ctrl #(
      .PEAK_WIN    (PW),
      .FRAME_LEN_W (FLW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .enable      (enable),
      .threshold   (threshold),
      .frame_len   (frame_len),
      .strm        (bus),
      .detect      (detect),
      .peak_value  (peak_value),
      .peak_offset (peak_offset),
      .state       (state)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        en;
      logic        vld;
      logic [31:0] m;
      logic [31:0] d;
      logic        ordy;
      logic [1:0]  st;
      logic        det;
      logic        rdy;
      logic        ov;
      logic        ol;
      logic [31:0] od;
      logic [31:0] pk;
      logic [2:0]  off;
   } vec_t;

   vec_t tbl[15];

   int unsigned tie_m[8] = '{150, 200, 180, 120, 200, 50, 40, 30};

   logic [31:0] rm[NRND];
   logic [31:0] rd[NRND];
   logic [32:0] exp_beat[$];
   logic [32:0] obs_beat[$];
   logic [34:0] exp_det[$];
   logic [34:0] obs_det[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic en, input logic vld, input logic [31:0] m,
                      input logic [31:0] d, input logic ordy);
      enable       = en;
      bus.m_tvalid = vld;
      bus.i_tvalid = vld;
      bus.m_tdata  = m;
      bus.i_tdata  = d;
      bus.o_tready = ordy;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear = 1'b0;
      drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic pair(input logic [31:0] m, input logic [31:0] d);
      drv(1'b1, 1'b1, m, d, 1'b1);
      #1;
      tick();
   endtask

   // One idle beat (IDLE -> SEARCH), then a 500 crossing and seven small
   // metrics: the window peak is the first pair, offset 7.
   task automatic reach_frame();
      drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      tick();
      pair(32'd500, 32'd0);
      repeat (7) pair(32'd10, 32'd0);
   endtask

   task automatic build_table();
      //           en  v   m    d       rdy  st det rdy ov ol od      pk   off
      tbl[0]  = '{1'b1,1'b1,32'd0,  32'h100,1'b1,2'd0,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[1]  = '{1'b1,1'b1,32'd100,32'h101,1'b1,2'd1,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[2]  = '{1'b1,1'b1,32'd150,32'h102,1'b1,2'd1,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[3]  = '{1'b1,1'b1,32'd200,32'h103,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[4]  = '{1'b1,1'b1,32'd180,32'h104,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[5]  = '{1'b1,1'b1,32'd120,32'h105,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[6]  = '{1'b1,1'b1,32'd90, 32'h106,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[7]  = '{1'b1,1'b1,32'd50, 32'h107,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[8]  = '{1'b1,1'b1,32'd40, 32'h108,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[9]  = '{1'b1,1'b1,32'd30, 32'h109,1'b1,2'd2,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd0,  3'd0};
      tbl[10] = '{1'b1,1'b1,32'd20, 32'hA0, 1'b1,2'd3,1'b1,1'b1,1'b1,1'b0,32'hA0, 32'd200,3'd6};
      tbl[11] = '{1'b1,1'b1,32'd25, 32'hA1, 1'b1,2'd3,1'b0,1'b1,1'b1,1'b0,32'hA1, 32'd200,3'd6};
      tbl[12] = '{1'b1,1'b1,32'd300,32'hA2, 1'b1,2'd3,1'b0,1'b1,1'b1,1'b0,32'hA2, 32'd200,3'd6};
      tbl[13] = '{1'b1,1'b1,32'd15, 32'hA3, 1'b1,2'd3,1'b0,1'b1,1'b1,1'b1,32'hA3, 32'd200,3'd6};
      tbl[14] = '{1'b1,1'b1,32'd10, 32'h200,1'b1,2'd1,1'b0,1'b1,1'b0,1'b0,32'h0,  32'd200,3'd6};
   endtask

   // Reference: scan the sequence of transferred pairs. A strict crossing
   // opens a PW-pair window whose first maximum is the peak; the next
   // max(frame_len,1) pairs are the frame; scanning then resumes.
   task automatic build_model(input int fl, input logic [31:0] thr);
      int i;
      int len;
      logic [31:0] pk;
      int idx;
      exp_beat.delete();
      exp_det.delete();
      len = (fl == 0) ? 1 : fl;
      i = 0;
      while (i < NRND) begin
         if (rm[i] > thr) begin
            if (i + PW > NRND) break;
            pk  = rm[i];
            idx = 0;
            for (int k = 1; k < PW; k++) begin
               if (rm[i+k] > pk) begin
                  pk  = rm[i+k];
                  idx = k;
               end
            end
            exp_det.push_back({pk, 3'(PW - 1 - idx)});
            i = i + PW;
            for (int k = 0; k < len; k++) begin
               if (i + k < NRND) exp_beat.push_back({(k == len - 1), rd[i+k]});
            end
            i = i + len;
         end else begin
            i++;
         end
      end
   endtask

   task automatic monitor();
      if (bus.o_tvalid && bus.o_tready) obs_beat.push_back({bus.o_tlast, bus.o_tdata});
      if (detect) obs_det.push_back({peak_value, peak_offset});
   endtask

   task automatic run_random(input int fl);
      int p;
      int cyc;
      logic vld;
      logic ordy;
      int nb;
      int nd;
      for (int k = 0; k < NRND; k++) begin
         if ($urandom_range(0, 99) < 6) rm[k] = 32'd100 + 32'd20 * $urandom_range(1, 5);
         else                           rm[k] = $urandom_range(0, 100);
         rd[k] = {16'(k), 16'($urandom)};
      end
      build_model(fl, 32'd100);
      obs_beat.delete();
      obs_det.delete();

      do_reset();
      threshold = 32'd100;
      frame_len = FLW'(fl);
      drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      repeat (3) tick();

      p   = 0;
      cyc = 0;
      while (p < NRND && cyc < 20000) begin
         vld  = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         drv(1'b1, vld, rm[p], rd[p], ordy);
         #1;
         monitor();
         chk("rnd ready_equal", {31'd0, bus.m_tready}, {31'd0, bus.i_tready});
         chk("rnd tvalid_outside_frame", {31'd0, bus.o_tvalid & (state != 2'd3)}, 32'd0);
         if (vld && bus.i_tready) p++;
         cyc++;
         tick();
      end
      chk("rnd pairs_consumed", p, NRND);

      repeat (4) begin
         drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
         #1;
         monitor();
         tick();
      end

      chk("rnd beat_count", obs_beat.size(), exp_beat.size());
      chk("rnd detect_count", obs_det.size(), exp_det.size());
      nb = (obs_beat.size() < exp_beat.size()) ? obs_beat.size() : exp_beat.size();
      nd = (obs_det.size() < exp_det.size()) ? obs_det.size() : exp_det.size();
      for (int k = 0; k < nb; k++) begin
         chk($sformatf("rnd beat%0d data", k), obs_beat[k][31:0], exp_beat[k][31:0]);
         chk($sformatf("rnd beat%0d last", k), {31'd0, obs_beat[k][32]}, {31'd0, exp_beat[k][32]});
      end
      for (int k = 0; k < nd; k++) begin
         chk($sformatf("rnd det%0d peak", k), obs_det[k][34:3], exp_det[k][34:3]);
         chk($sformatf("rnd det%0d offset", k), {29'd0, obs_det[k][2:0]}, {29'd0, exp_det[k][2:0]});
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      clear     = 1'b0;
      threshold = 32'd100;
      frame_len = 16'd4;
      drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      build_table();

      // ---- basic detect + 4-beat frame, cycle by cycle ----
      do_reset();
      #1;
      chk("reset state", {30'd0, state}, 32'd0);
      chk("reset detect", {31'd0, detect}, 32'd0);
      chk("reset peak_value", peak_value, 32'd0);
      chk("reset peak_offset", {29'd0, peak_offset}, 32'd0);
      chk("reset o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
      chk("reset o_tlast", {31'd0, bus.o_tlast}, 32'd0);
      for (int k = 0; k < 15; k++) begin
         drv(tbl[k].en, tbl[k].vld, tbl[k].m, tbl[k].d, tbl[k].ordy);
         #1;
         chk($sformatf("vec%0d state", k), {30'd0, state}, {30'd0, tbl[k].st});
         chk($sformatf("vec%0d detect", k), {31'd0, detect}, {31'd0, tbl[k].det});
         chk($sformatf("vec%0d m_tready", k), {31'd0, bus.m_tready}, {31'd0, tbl[k].rdy});
         chk($sformatf("vec%0d i_tready", k), {31'd0, bus.i_tready}, {31'd0, tbl[k].rdy});
         chk($sformatf("vec%0d o_tvalid", k), {31'd0, bus.o_tvalid}, {31'd0, tbl[k].ov});
         chk($sformatf("vec%0d o_tlast", k), {31'd0, bus.o_tlast}, {31'd0, tbl[k].ol});
         chk($sformatf("vec%0d peak_value", k), peak_value, tbl[k].pk);
         chk($sformatf("vec%0d peak_offset", k), {29'd0, peak_offset}, {29'd0, tbl[k].off});
         if (tbl[k].ov) chk($sformatf("vec%0d o_tdata", k), bus.o_tdata, tbl[k].od);
         tick();
      end

      // ---- equal peaks at window pairs 2 and 5, then back-pressure ----
      do_reset();
      drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      tick();
      for (int k = 0; k < 8; k++) pair(tie_m[k], 32'd0);
      drv(1'b1, 1'b1, 32'd5, 32'hB0, 1'b1);
      #1;
      chk("tie state", {30'd0, state}, 32'd3);
      chk("tie detect", {31'd0, detect}, 32'd1);
      chk("tie peak_value", peak_value, 32'd200);
      chk("tie peak_offset", {29'd0, peak_offset}, 32'd6);
      chk("bp beat0 data", bus.o_tdata, 32'hB0);
      tick();
      for (int k = 0; k < 2; k++) begin
         drv(1'b1, 1'b1, 32'd5, 32'hB1, 1'b0);
         #1;
         chk("bp stall i_tready", {31'd0, bus.i_tready}, 32'd0);
         chk("bp stall m_tready", {31'd0, bus.m_tready}, 32'd0);
         chk("bp stall o_tvalid", {31'd0, bus.o_tvalid}, 32'd1);
         chk("bp stall data", bus.o_tdata, 32'hB1);
         chk("bp stall detect", {31'd0, detect}, 32'd0);
         tick();
      end
      drv(1'b1, 1'b1, 32'd5, 32'hB1, 1'b1);
      #1;
      chk("bp beat1 i_tready", {31'd0, bus.i_tready}, 32'd1);
      chk("bp beat1 o_tlast", {31'd0, bus.o_tlast}, 32'd0);
      tick();
      drv(1'b1, 1'b1, 32'd5, 32'hB2, 1'b1);
      #1;
      chk("bp beat2 data", bus.o_tdata, 32'hB2);
      chk("bp beat2 o_tlast", {31'd0, bus.o_tlast}, 32'd0);
      tick();
      drv(1'b1, 1'b1, 32'd5, 32'hB3, 1'b1);
      #1;
      chk("bp beat3 data", bus.o_tdata, 32'hB3);
      chk("bp beat3 o_tlast", {31'd0, bus.o_tlast}, 32'd1);
      tick();
      drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      chk("bp after state", {30'd0, state}, 32'd1);
      chk("bp after o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
      tick();

      // ---- enable dropped while tracking ----
      pair(32'd150, 32'd0);
      drv(1'b1, 1'b1, 32'd10, 32'd0, 1'b1);
      #1;
      chk("endrop track state", {30'd0, state}, 32'd2);
      tick();
      drv(1'b0, 1'b1, 32'd300, 32'd0, 1'b1);
      #1;
      tick();
      repeat (8) begin
         drv(1'b0, 1'b1, 32'd400, 32'd0, 1'b1);
         #1;
         chk("endrop state", {30'd0, state}, 32'd0);
         chk("endrop detect", {31'd0, detect}, 32'd0);
         chk("endrop o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
         tick();
      end
      chk("endrop peak held", peak_value, 32'd200);

      // ---- reset in the middle of a frame ----
      reach_frame();
      drv(1'b1, 1'b1, 32'd1, 32'hC0, 1'b1);
      #1;
      chk("rst-mid o_tvalid before", {31'd0, bus.o_tvalid}, 32'd1);
      chk("rst-mid peak_value", peak_value, 32'd500);
      chk("rst-mid peak_offset", {29'd0, peak_offset}, 32'd7);
      tick();
      reset = 1'b1;
      drv(1'b1, 1'b1, 32'd1, 32'hC1, 1'b1);
      #1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst-mid state", {30'd0, state}, 32'd0);
      chk("rst-mid o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
      chk("rst-mid o_tlast", {31'd0, bus.o_tlast}, 32'd0);
      chk("rst-mid peak cleared", peak_value, 32'd0);
      tick();

      // ---- soft clear in the middle of a frame ----
      reach_frame();
      drv(1'b1, 1'b1, 32'd1, 32'hC2, 1'b1);
      #1;
      chk("clr-mid o_tvalid before", {31'd0, bus.o_tvalid}, 32'd1);
      tick();
      clear = 1'b1;
      #1;
      tick();
      clear = 1'b0;
      #1;
      chk("clr-mid state", {30'd0, state}, 32'd0);
      chk("clr-mid o_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
      chk("clr-mid peak_offset", {29'd0, peak_offset}, 32'd0);
      tick();

      // ---- frame_len = 0 gives single-beat frames ----
      frame_len = 16'd0;
      reach_frame();
      drv(1'b1, 1'b1, 32'd1, 32'hD0, 1'b1);
      #1;
      chk("len0 o_tvalid", {31'd0, bus.o_tvalid}, 32'd1);
      chk("len0 o_tlast", {31'd0, bus.o_tlast}, 32'd1);
      chk("len0 o_tdata", bus.o_tdata, 32'hD0);
      tick();
      drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      chk("len0 back to search", {30'd0, state}, 32'd1);
      tick();
      reach_frame();
      drv(1'b0, 1'b1, 32'd1, 32'hD1, 1'b1);
      #1;
      chk("len0 en-off o_tlast", {31'd0, bus.o_tlast}, 32'd1);
      tick();
      drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      chk("len0 en-off to idle", {30'd0, state}, 32'd0);
      tick();

      // ---- random streams against the reference model ----
      run_random(3);
      run_random(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/schmidl_cox_sync_ctrl.md
SCHMIDL_COX_SYNC_CTRL -- requirements
Module: schmidl_cox_sync_ctrl

Interface
REQ-001 Parameter PEAK_WIN, default 512, number of metric/sample pairs in the peak-search window after the first threshold crossing.
REQ-002 Parameter FRAME_LEN_W, default 16, width of frame_len.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clear  in  1  synchronous soft clear, same effect as reset.
REQ-006 enable  in  1  1 = search for frames; 0 = discard input.
REQ-007 threshold  in  32  unsigned metric threshold, compared live every pair.
REQ-008 frame_len  in  FRAME_LEN_W  samples per output frame, sampled on entry to FRAME.
REQ-009 m_tdata/m_tvalid/m_tready  in/in/out  32/1/1  metric stream M(d), unsigned.
REQ-010 i_tdata/i_tvalid/i_tready  in/in/out  32/1/1  sample stream [I,Q], aligned 1:1 with metric.
REQ-011 o_tdata/o_tlast/o_tvalid/o_tready  out/out/out/in  32/1/1/1  framed sample output.
REQ-012 detect  out  1  one-cycle pulse on frame start.
REQ-013 peak_value  out  32  peak metric of last detection.
REQ-014 peak_offset  out  clog2(PEAK_WIN)  pairs from peak to window end.
REQ-015 state  out  2  current FSM state, for status readback.

Function
REQ-016 A pair SHALL transfer only when m_tvalid and i_tvalid are both 1 and the pair is accepted; m_tready and i_tready SHALL always be equal.
REQ-017 States: IDLE, SEARCH, TRACK, FRAME.
REQ-018 IDLE: readies = 1 (pairs discarded); go to SEARCH when enable = 1.
REQ-019 SEARCH: readies = 1, pairs discarded; on pair with m_tdata > threshold (strict), go to TRACK, load peak = m_tdata, window count = 1, offset = 0.
REQ-020 TRACK: readies = 1, pairs discarded; each pair increments window count; m_tdata > peak (strict; ties keep earlier) loads peak and resets offset to 0, else offset increments.
REQ-021 TRACK ends on the pair that makes window count = PEAK_WIN; then go to FRAME, pulse detect one cycle later, register peak_value/peak_offset (held until next detect).
REQ-022 FRAME: o_tdata = i_tdata, o_tvalid = m_tvalid & i_tvalid, readies = o_tready (zero latency, combinational); metric discarded in lockstep.
REQ-023 FRAME: frame counter counts output beats; o_tlast = 1 on beat frame_len; frame_len = 0 SHALL be treated as 1.
REQ-024 After the tlast beat: go to SEARCH if enable = 1, else IDLE.
REQ-025 enable = 0 in SEARCH or TRACK: go to IDLE next cycle, no detect; in FRAME: frame completes, then IDLE.
REQ-026 o_tvalid SHALL be 0 in every state except FRAME.
REQ-027 threshold changes take effect on the next pair; frame_len changes mid-frame are ignored.
REQ-028 Counters SHALL saturate-free wrap only via explicit reload; window counter width clog2(PEAK_WIN+1).

Reset
REQ-029 On reset or clear: state = IDLE, detect = 0, peak_value = 0, peak_offset = 0, counters = 0, o_tvalid = 0, o_tlast = 0.
REQ-030 Reset or clear mid-frame SHALL abort the frame without a tlast beat.

Structure
REQ-031 Package schmidl_cox_pkg SHALL hold the state enum and PEAK_WIN default.
REQ-032 Peak max/offset tracking SHALL be sub-module sc_peak_tracker (load, update, value, offset).
REQ-033 Implementation is single FSM plus counters, no RAM.

Verification (PEAK_WIN=8, frame_len=4, threshold=100)
REQ-034 Metric 0,0,150,200,180,120,90,50,40,30,... -> detect after 8th pair from crossing, peak_value=200, peak_offset=6.
REQ-035 Continuing stream after REQ-034 -> next 4 samples on output, o_tlast on 4th, state returns to SEARCH.
REQ-036 Equal peaks 200 at window pairs 2 and 5 -> peak_offset=6 (first kept).
REQ-037 o_tready toggled 1,0,0,1 in FRAME -> no sample lost or duplicated; i_tready mirrors o_tready.
REQ-038 enable dropped in TRACK -> IDLE, no detect; reset mid-FRAME -> o_tvalid=0 next cycle, state IDLE.
REQ-039 frame_len=0 -> single-beat frame with o_tlast=1.
